// File: rtl/alu_acc_pipe_if.sv
// -----------------------------------------------------------------------------
// alu_acc_pipe_if
// Bundles the operand/result signals of alu_acc_pipe.
//
// Handshake: i_valid qualifies i_sel/i_data1/i_data2 on each rising clk edge.
// There is no ready signal because the pipeline never stalls. o_valid is a
// one-cycle strobe that marks the cycle in which o_data reflects a newly
// committed operation.
//
// Signals (driver -> pipe):
//   i_valid, i_clear, i_sel[1:0], i_data1[DATA_W-1:0], i_data2[DATA_W-1:0]
// Signals (pipe -> driver):
//   o_data[ACC_W-1:0], o_overflow, o_valid, o_count[CNT_W-1:0]
// Modports: master (stimulus/front end), slave (the pipeline).
// -----------------------------------------------------------------------------
interface alu_acc_pipe_if #(
  parameter int DATA_W = 3,
  parameter int ACC_W  = 6,
  parameter int CNT_W  = 8
);
  logic              i_valid;
  logic              i_clear;
  logic [1:0]        i_sel;
  logic [DATA_W-1:0] i_data1;
  logic [DATA_W-1:0] i_data2;
  logic [ACC_W-1:0]  o_data;
  logic              o_overflow;
  logic              o_valid;
  logic [CNT_W-1:0]  o_count;

  modport master (
    output i_valid, i_clear, i_sel, i_data1, i_data2,
    input  o_data, o_overflow, o_valid, o_count
  );

  modport slave (
    input  i_valid, i_clear, i_sel, i_data1, i_data2,
    output o_data, o_overflow, o_valid, o_count
  );
endinterface

// File: rtl/alu_acc_pipe.sv
// -----------------------------------------------------------------------------
// alu_acc_pipe
// Two-stage pipelined select-and-accumulate datapath with registered outputs.
//   Stage 1 : forms the operand combination (A+B or A*B) at 2*DATA_W bits.
//   Stage 2 : adds/subtracts/loads it into the ACC_W accumulator, updates the
//             sticky overflow flag and the saturating commit counter.
//   Output  : registered copy of stage-2 state, so operands captured at edge N
//             appear on o_data with o_valid=1 after edge N+2.
//
// Ports:
//   clk      : rising-edge clock
//   i_rst_n  : asynchronous active-low reset
//   bus      : alu_acc_pipe_if.slave (operands, select, clear, results)
//
// sel: 0 ADD (acc+A+B), 1 SUB (acc-(A+B)), 2 MAC (acc+A*B), 3 LOAD (acc=A+B).
//
// Optional build macro: ALU_ACC_SATURATE_EN -- when defined, ADD/MAC carry
// clamps the accumulator to all-ones and SUB borrow clamps it to zero instead
// of wrapping. The overflow flag behaves the same in both builds.
// -----------------------------------------------------------------------------
module alu_acc_pipe #(
  parameter int DATA_W = 3,
  parameter int ACC_W  = 6,
  parameter int CNT_W  = 8
) (
  input  logic          clk,
  input  logic          i_rst_n,
  alu_acc_pipe_if.slave bus
);

  localparam int OP_W  = 2 * DATA_W;
  localparam int EXT_W = ACC_W + 1 - OP_W;

  localparam logic [1:0] SEL_ADD  = 2'd0;
  localparam logic [1:0] SEL_SUB  = 2'd1;
  localparam logic [1:0] SEL_MAC  = 2'd2;
  localparam logic [1:0] SEL_LOAD = 2'd3;

  generate
    if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
      $fatal(1, "alu_acc_pipe: ACC_W must be >= 2*DATA_W");
    end
  endgenerate

  // Stage 1 registers
  logic             s1_vld;
  logic [1:0]       s1_sel;
  logic [OP_W-1:0]  s1_op;

  // Stage 2 (architectural) state
  logic             s2_vld;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [CNT_W-1:0] cnt;

  // Stage 1 combinational operand
  logic [OP_W-1:0]  a_ext;
  logic [OP_W-1:0]  b_ext;
  logic [OP_W-1:0]  op_next;

  always_comb begin
    a_ext   = {{DATA_W{1'b0}}, bus.i_data1};
    b_ext   = {{DATA_W{1'b0}}, bus.i_data2};
    op_next = a_ext + b_ext;
    if (bus.i_sel == SEL_MAC) begin
      op_next = a_ext * b_ext;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_vld <= 1'b0;
      s1_sel <= '0;
      s1_op  <= '0;
    end else if (bus.i_clear) begin
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= bus.i_valid;
      if (bus.i_valid) begin
        s1_sel <= bus.i_sel;
        s1_op  <= op_next;
      end
    end
  end

  // Stage 2 arithmetic at ACC_W+1 bits; the top bit is the carry/borrow.
  logic [ACC_W:0]   op_wide;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W:0]   diff_wide;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_next;

  always_comb begin
    op_wide   = {{EXT_W{1'b0}}, s1_op};
    sum_wide  = {1'b0, acc} + op_wide;
    diff_wide = {1'b0, acc} - op_wide;
    acc_next  = acc;
    ovf_next  = ovf;
    case (s1_sel)
      SEL_ADD, SEL_MAC: begin
        acc_next = sum_wide[ACC_W-1:0];
`ifdef ALU_ACC_SATURATE_EN
        if (sum_wide[ACC_W]) acc_next = '1;
`endif
        if (sum_wide[ACC_W]) ovf_next = 1'b1;
      end
      SEL_SUB: begin
        acc_next = diff_wide[ACC_W-1:0];
`ifdef ALU_ACC_SATURATE_EN
        if (diff_wide[ACC_W]) acc_next = '0;
`endif
        if (diff_wide[ACC_W]) ovf_next = 1'b1;
      end
      default: begin
        // LOAD: flag untouched
        acc_next = op_wide[ACC_W-1:0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_vld <= 1'b0;
      acc    <= '0;
      ovf    <= 1'b0;
      cnt    <= '0;
    end else if (bus.i_clear) begin
      s2_vld <= 1'b0;
      acc    <= '0;
      ovf    <= 1'b0;
      cnt    <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        acc <= acc_next;
        ovf <= ovf_next;
        if (cnt != {CNT_W{1'b1}}) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Output registers; clear zeroes them on the same edge as the internal state.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_data     <= '0;
      bus.o_overflow <= 1'b0;
      bus.o_valid    <= 1'b0;
      bus.o_count    <= '0;
    end else if (bus.i_clear) begin
      bus.o_data     <= '0;
      bus.o_overflow <= 1'b0;
      bus.o_valid    <= 1'b0;
      bus.o_count    <= '0;
    end else begin
      bus.o_data     <= acc;
      bus.o_overflow <= ovf;
      bus.o_valid    <= s2_vld;
      bus.o_count    <= cnt;
    end
  end

endmodule
